obc_da_dft_bin: RTL and testbench

Parametrised, bit-serial offset-binary-coded (OBC) distributed-arithmetic engine that computes one real-valued DFT component y = Σ c_n·x_n over a block of N signed samples. Coefficients are run-time programmable, so one instance serves any bin and either the real or the imaginary part. Each sample bit-slice is folded pairwise into 2-entry tables with sign control. Work runs over W cycles, one slice per cycle, and the result leaves on a valid/ready handshake. It sits between the sample framer and the spectrum output stage of the N-point DFT datapath.

---
 rtl/obc_da_dft_bin.sv | 125 ++++++++++++
 tb/tb_obc_da_dft_bin.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obc_da_dft_bin.sv
// Bit-serial offset-binary-coded distributed-arithmetic engine computing one real
// DFT component y = sum(c_n * x_n) over an N-sample block, one bit-slice per cycle.
module obc_da_dft_bin #(
    parameter int N  = 16,
    parameter int W  = 16,
    parameter int CW = 16,
    localparam int OW = CW + W + $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [$clog2(N)-1:0]  cfg_addr,
    input  logic signed [CW-1:0]  cfg_data,
    output logic                  cfg_busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*W-1:0]        in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [OW-1:0]  out_data
);
    localparam int AW   = $clog2(N);
    localparam int NP   = N / 2;
    localparam int TW   = CW + 1;
    localparam int QW   = CW + AW + 1;   // slice sum can reach exactly +N*2^(CW-1)
    localparam int KW   = CW + AW;
    localparam int ACCW = OW + 1;
    localparam int CNTW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic signed [CW-1:0]   coef_q [N];
    logic signed [CW-1:0]   coef_d [N];
    logic [W-1:0]           x_q [N];
    logic [W-1:0]           x_d [N];
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic signed [QW-1:0]   term [NP];
    logic signed [QW-1:0]   q_sum;
    logic signed [KW-1:0]   k_sum;
    logic                   sign_slice;
    logic                   accept;

    always_comb begin
        for (int i = 0; i < N; i++) coef_d[i] = coef_q[i];
        if (cfg_we && state_q != RUN) coef_d[cfg_addr] = cfg_data;
    end

    // Offset taken from the post-write coefficients so a write coincident with
    // acceptance is already reflected in the initial accumulator value.
    always_comb begin
        k_sum = '0;
        for (int i = 0; i < N; i++) k_sum = k_sum + KW'(coef_d[i]);
    end

    assign sign_slice = (cnt_q == CNTW'(W - 1));

    for (genvar gi = 0; gi < NP; gi++) begin : g_pair
        logic signed [TW-1:0] ca, cb, entry;
        logic                 bit_a, bit_b;
        assign ca       = TW'(coef_q[2*gi]);
        assign cb       = TW'(coef_q[2*gi+1]);
        assign bit_a    = x_q[2*gi][0];
        assign bit_b    = x_q[2*gi+1][0];
        assign entry    = (bit_a ^ bit_b) ? (ca - cb) : (ca + cb);
        assign term[gi] = (~bit_a ^ sign_slice) ? -QW'(entry) : QW'(entry);
    end

    always_comb begin
        q_sum = '0;
        for (int g = 0; g < NP; g++) q_sum = q_sum + term[g];
    end

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_ready && in_valid;
    assign out_valid = (state_q == DONE);
    assign cfg_busy  = (state_q == RUN);
    assign out_data  = out_valid ? OW'(acc_q >>> 1) : '0;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < N; i++) x_d[i] = x_q[i];
        case (state_q)
            RUN: begin
                acc_d = acc_q + (ACCW'(q_sum) <<< cnt_q);
                for (int i = 0; i < N; i++) x_d[i] = x_q[i] >> 1;
                cnt_d = cnt_q + CNTW'(1);
                if (sign_slice) state_d = DONE;
            end
            DONE: begin
                if (out_ready && !in_valid) state_d = IDLE;
            end
            default: ;
        endcase
        if (accept) begin
            for (int i = 0; i < N; i++) x_d[i] = in_data[i*W +: W];
            acc_d   = -ACCW'(k_sum);
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < N; i++) begin
                coef_q[i] <= '0;
                x_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < N; i++) begin
                coef_q[i] <= coef_d[i];
                x_q[i]    <= x_d[i];
            end
        end
    end
endmodule

// File: tb/tb_obc_da_dft_bin.sv
// Self-checking bench for obc_da_dft_bin: fixed vector table, hand-written
// handshake/config/reset sequences, and random blocks against a dot-product model.
module tb_obc_da_dft_bin;
    localparam int N  = 16;
    localparam int W  = 16;
    localparam int CW = 16;
    localparam int AW = $clog2(N);
    localparam int OW = CW + W + AW;

    typedef struct packed {
        logic [N*CW-1:0]    c;
        logic [N*W-1:0]     x;
        logic signed [63:0] y;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [AW-1:0]        cfg_addr = '0;
    logic signed [CW-1:0] cfg_data = '0;
    logic                 cfg_busy;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [N*W-1:0]       in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [OW-1:0] out_data;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    obc_da_dft_bin #(.N(N), .W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_busy(cfg_busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*CW-1:0] pack_c(input int c[N]);
        logic [N*CW-1:0] r;
        for (int n = 0; n < N; n++) r[n*CW +: CW] = CW'(c[n]);
        return r;
    endfunction

    function automatic logic [N*W-1:0] pack_x(input int x[N]);
        logic [N*W-1:0] r;
        for (int n = 0; n < N; n++) r[n*W +: W] = W'(x[n]);
        return r;
    endfunction

    // Reference: plain dot product of the signed integer coefficients and samples.
    function automatic longint model(input int c[N], input int x[N]);
        longint s = 0;
        for (int n = 0; n < N; n++) s += longint'(c[n]) * longint'(x[n]);
        return s;
    endfunction

    function automatic vec_t mk(input int c[N], input int x[N], input longint y);
        vec_t v;
        v.c = pack_c(c);
        v.x = pack_x(x);
        v.y = y;
        return v;
    endfunction

    task automatic write_coef(input int a, input int v);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = CW'(v);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic load_cpk(input logic [N*CW-1:0] c);
        for (int n = 0; n < N; n++) write_coef(n, int'($signed(c[n*CW +: CW])));
    endtask

    task automatic start_block(input logic [N*W-1:0] x, input string tag);
        in_data  = x;
        in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, longint'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check({tag, " cfg_busy"}, longint'(cfg_busy), 1);
    endtask

    task automatic wait_valid(input int lat, input string tag);
        int cyc = 0;
        while (!out_valid && cyc < 4*W) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, lat);
    endtask

    task automatic finish_block(input longint exp, input int lat, input string tag);
        wait_valid(lat, tag);
        check({tag, " out_data"}, out_data, exp);
        $display("%s: y=%0d expected %0d", tag, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " released"}, longint'(out_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   ca[N], xa[N], sin_c[N];

        sin_c = '{0, -12539, -23170, -30273, -32767, -30273, -23170, -12539,
                  0, 12539, 23170, 30273, 32767, 30273, 23170, 12539};
        for (int n = 0; n < N; n++) begin ca[n] = 1; xa[n] = 1; end
        tbl[0] = mk(ca, xa, 16);
        for (int n = 0; n < N; n++) begin ca[n] = n; xa[n] = -1; end
        tbl[1] = mk(ca, xa, -120);
        for (int n = 0; n < N; n++) xa[n] = n;
        tbl[2] = mk(ca, xa, 1240);
        for (int n = 0; n < N; n++) begin ca[n] = -32768; xa[n] = -32768; end
        tbl[3] = mk(ca, xa, 64'sd17179869184);
        for (int n = 0; n < N; n++) xa[n] = 32767;
        tbl[4] = mk(ca, xa, -64'sd17179344896);
        for (int n = 0; n < N; n++) xa[n] = 0;
        xa[4] = 1000;
        tbl[5] = mk(sin_c, xa, -32767000);
        xa[4] = 0;
        xa[0] = 1000;
        tbl[6] = mk(sin_c, xa, 0);

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset in_ready", longint'(in_ready), 1);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_data", out_data, 0);
        check("reset cfg_busy", longint'(cfg_busy), 0);
        for (int n = 0; n < N; n++) xa[n] = 1;
        start_block(pack_x(xa), "reset coefs");
        finish_block(0, W, "reset coefs");

        for (int k = 0; k < 7; k++) begin
            load_cpk(tbl[k].c);
            start_block(tbl[k].x, $sformatf("tbl%0d", k));
            finish_block(tbl[k].y, W, $sformatf("tbl%0d", k));
        end

        // Backpressure then back-to-back acceptance in the release cycle
        for (int n = 0; n < N; n++) begin ca[n] = n; xa[n] = 1; end
        load_cpk(pack_c(ca));
        start_block(pack_x(xa), "bp");
        wait_valid(W, "bp");
        for (int i = 0; i < 5; i++) begin
            check("bp hold out_data", out_data, 120);
            check("bp hold in_ready", longint'(in_ready), 0);
            tick();
        end
        $display("bp: held y=%0d for 5 cycles", out_data);
        for (int n = 0; n < N; n++) xa[n] = n;
        in_data   = pack_x(xa);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("b2b in_ready", longint'(in_ready), 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b out_valid dropped", longint'(out_valid), 0);
        check("b2b cfg_busy", longint'(cfg_busy), 1);
        finish_block(1240, W, "b2b");

        // Coefficient write in the acceptance cycle applies to the new block
        for (int n = 0; n < N; n++) xa[n] = 0;
        xa[3] = 2;
        cfg_we   = 1'b1;
        cfg_addr = AW'(3);
        cfg_data = 16'sd5;
        in_data  = pack_x(xa);
        in_valid = 1'b1;
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        finish_block(10, W, "cfg+accept");

        // Write lockout during RUN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        write_coef(3, 7);
        xa[3] = 1;
        start_block(pack_x(xa), "lockout");
        write_coef(3, 9);
        finish_block(7, W - 1, "lockout");
        start_block(pack_x(xa), "lockout kept");
        finish_block(7, W, "lockout kept");

        // Reset mid-RUN aborts the block and clears coefficients
        start_block(pack_x(xa), "abort");
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("abort out_valid", longint'(out_valid), 0);
        check("abort in_ready", longint'(in_ready), 1);
        check("abort cfg_busy", longint'(cfg_busy), 0);
        check("abort out_data", out_data, 0);
        tick();
        rst_n = 1'b1;
        $display("abort: reset during RUN");
        start_block(pack_x(xa), "post-abort");
        finish_block(0, W, "post-abort");

        // Random blocks against the dot-product model
        for (int t = 0; t < 12; t++) begin
            for (int n = 0; n < N; n++) begin
                ca[n] = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
                xa[n] = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
            end
            load_cpk(pack_c(ca));
            start_block(pack_x(xa), $sformatf("rnd%0d", t));
            finish_block(model(ca, xa), W, $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
